mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Pipeline stage directly downstream of the execute stage. It holds the X/M latch, drives the data-memory port for lw/sw, and holds the M/W latch that feeds register-file writeback. It resolves the final destination register and write value for jal, setx and arithmetic-exception (rstatus) cases. It publishes M- and W-stage results for the bypass network and keeps a retired-instruction counter.

Parameters:
DMEM_AW, 12, data-memory address width (address = low DMEM_AW bits of ALU result)
RSTATUS, 30, register index written on arithmetic exception and by setx
RLINK, 31, register index written by jal

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high; clears all state
x_valid  input  1  execute holds a real instruction
x_ir  input  32  instruction in execute
x_alu_out  input  32  execute result (ALU or mult/div)
x_b_out  input  32  $rd value for sw
x_pc_jal  input  32  PC+1 for jal
x_overflow  input  1  execute arithmetic exception
x_case_jal  input  1  execute decoded jal
stall  input  1  execute's disable_latches (mult/div in progress)
dmem_addr  output  DMEM_AW  data-memory address
dmem_data  output  32  store data
dmem_wren  output  1  store enable
dmem_q  input  32  load data, registered in dmem, valid the cycle after dmem_addr
m_rd  output  5  M-stage destination (bypass)
m_value  output  32  M-stage write value (bypass; not valid for lw)
m_regwrite  output  1  M-stage will write a register
w_rd  output  5  writeback destination
w_data  output  32  writeback data
w_regwrite  output  1  register-file write enable
retired_count  output  32  instructions completed through W

Behaviour:
- Reset (sync): m_valid=0, w_valid=0, X/M and M/W fields=0, retired_count=0. After the reset edge: dmem_wren=0, m_regwrite=0, w_regwrite=0, w_rd=0, w_data=0.
- Opcode = ir[31:27]. R-type 00000 (ALUop ir[6:2]: add 00000, sub 00001, mul 00110, div 00111); addi 00101; sw 00111; lw 01000; jal 00011; setx 10101. All others: no regwrite, no store.
- X/M capture, every edge: if stall=1, load a bubble (valid=0, ir=0). The stalled instruction stays in execute; M/W still advances. Otherwise capture x_valid, x_ir, x_b_out, and the resolved rd and value below.
- Resolution at capture, by priority:
  1. x_overflow on add/addi/sub/mul/div: rd=RSTATUS; value=1/2/3/4/5 respectively.
  2. jal (x_case_jal): rd=RLINK; value=x_pc_jal.
  3. setx: rd=RSTATUS; value={5'b0, ir[26:0]}.
  4. Otherwise: rd=ir[26:22]; value=x_alu_out.
- The raw x_alu_out is also kept for the address. An overflowed instruction never stores or loads.
- m_regwrite = m_valid & (R-type | addi | lw | jal | setx | overflow case) & (m_rd != 0).
- Memory, combinational from X/M: dmem_addr = alu_out[DMEM_AW-1:0]; dmem_data = b; dmem_wren = m_valid & sw. Exactly one write per sw.
- M/W capture, every edge, unconditional: valid, rd, value, regwrite, is_lw.
- w_data = is_lw ? dmem_q : value. w_regwrite = w_valid & regwrite. A lw is a one-cycle load: address in M, data in W.
- retired_count increments by 1 on each edge where w_valid=1; bubbles are not counted. Wraps at 2^32-1 -> 0.
- Latency: instruction in X at edge N appears in M after edge N and in W after edge N+1.
- Reset coinciding with stall or valid input: reset wins.

Test Plan:
- add r3 (alu_out=7, rd=3, no overflow) -> m_rd=3, m_value=7 after edge 1; w_rd=3, w_data=7, w_regwrite=1 after edge 2; retired_count=1.
- sw then lw at alu_out=0x00000A05, b=0xDEADBEEF -> dmem_wren=1 for one cycle with dmem_addr=0xA05; lw to r5 gives w_data=dmem_q=0xDEADBEEF; w_regwrite=0 for the sw.
- addi with x_overflow=1 -> w_rd=30, w_data=2. sub with overflow -> w_data=3. div with overflow -> w_data=5. dmem_wren stays 0.
- jal with x_pc_jal=0x40 -> w_rd=31, w_data=0x40. setx T=0x123 -> w_rd=30, w_data=0x123. add to r0 -> w_regwrite=0.
- stall=1 for 3 cycles with a valid mul in X -> X/M holds bubbles and m_regwrite=0; an older instruction already in M still completes; retired_count rises by exactly 1 per real instruction.
- reset asserted while a sw is in M -> after the edge, dmem_wren=0, w_regwrite=0, retired_count=0.
- preload retired_count=0xFFFFFFFF, retire one instruction -> retired_count=0.

Source files
------------

// File: rtl/mem_stage_if.sv
// Bus between execute, the memory stage, data memory and the bypass/writeback consumers.
// slave is the memory-stage side; master is the environment (execute, dmem, regfile).
interface mem_stage_if #(
  parameter int DMEM_AW = 12
);
  logic               x_valid;
  logic [31:0]        x_ir;
  logic [31:0]        x_alu_out;
  logic [31:0]        x_b_out;
  logic [31:0]        x_pc_jal;
  logic               x_overflow;
  logic               x_case_jal;
  logic               stall;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [31:0]        dmem_data;
  logic               dmem_wren;
  logic [31:0]        dmem_q;
  logic [4:0]         m_rd;
  logic [31:0]        m_value;
  logic               m_regwrite;
  logic [4:0]         w_rd;
  logic [31:0]        w_data;
  logic               w_regwrite;
  logic [31:0]        retired_count;

  modport slave (
    input  x_valid, x_ir, x_alu_out, x_b_out, x_pc_jal, x_overflow, x_case_jal, stall, dmem_q,
    output dmem_addr, dmem_data, dmem_wren, m_rd, m_value, m_regwrite,
    output w_rd, w_data, w_regwrite, retired_count
  );

  modport master (
    output x_valid, x_ir, x_alu_out, x_b_out, x_pc_jal, x_overflow, x_case_jal, stall, dmem_q,
    input  dmem_addr, dmem_data, dmem_wren, m_rd, m_value, m_regwrite,
    input  w_rd, w_data, w_regwrite, retired_count
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: X/M latch -> dmem port -> M/W latch; X to M in 1 edge, M to W in 1 edge.
// stall turns the X/M capture into a bubble while M/W keeps advancing; no other backpressure.
module mem_stage #(
  parameter int DMEM_AW = 12,
  parameter int RSTATUS = 30,
  parameter int RLINK   = 31
) (
  input logic        clock,
  input logic        reset,
  mem_stage_if.slave bus
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;
  localparam logic [4:0] RD_STATUS = 5'(RSTATUS);
  localparam logic [4:0] RD_LINK   = 5'(RLINK);

  logic [4:0]  x_op;
  logic [2:0]  ovf_code;
  logic        x_ovf_case;
  logic [4:0]  x_rd_res;
  logic [31:0] x_val_res;

  // Priority: arithmetic exception, then jal, then setx, then the plain result.
  always_comb begin
    x_op     = bus.x_ir[31:27];
    ovf_code = 3'd0;
    if (x_op == OP_RTYPE) begin
      case (bus.x_ir[6:2])
        ALU_ADD: ovf_code = 3'd1;
        ALU_SUB: ovf_code = 3'd3;
        ALU_MUL: ovf_code = 3'd4;
        ALU_DIV: ovf_code = 3'd5;
        default: ovf_code = 3'd0;
      endcase
    end else if (x_op == OP_ADDI) begin
      ovf_code = 3'd2;
    end
    x_ovf_case = bus.x_overflow && (ovf_code != 3'd0);
    x_rd_res   = bus.x_ir[26:22];
    x_val_res  = bus.x_alu_out;
    if (x_ovf_case) begin
      x_rd_res  = RD_STATUS;
      x_val_res = {29'd0, ovf_code};
    end else if (bus.x_case_jal) begin
      x_rd_res  = RD_LINK;
      x_val_res = bus.x_pc_jal;
    end else if (x_op == OP_SETX) begin
      x_rd_res  = RD_STATUS;
      x_val_res = {5'd0, bus.x_ir[26:0]};
    end
  end

  logic               m_valid;
  logic [4:0]         m_op;
  logic [DMEM_AW-1:0] m_addr;
  logic [31:0]        m_b;
  logic [4:0]         m_rd;
  logic [31:0]        m_value;
  logic               m_ovf;
  logic               m_jal;

  always_ff @(posedge clock) begin
    if (reset || bus.stall) begin
      m_valid <= 1'b0;
      m_op    <= '0;
      m_addr  <= '0;
      m_b     <= '0;
      m_rd    <= '0;
      m_value <= '0;
      m_ovf   <= 1'b0;
      m_jal   <= 1'b0;
    end else begin
      m_valid <= bus.x_valid;
      m_op    <= x_op;
      m_addr  <= bus.x_alu_out[DMEM_AW-1:0];
      m_b     <= bus.x_b_out;
      m_rd    <= x_rd_res;
      m_value <= x_val_res;
      m_ovf   <= x_ovf_case;
      m_jal   <= bus.x_case_jal;
    end
  end

  logic m_writes;
  logic m_is_lw;
  logic m_regwrite;

  always_comb begin
    m_writes   = (m_op == OP_RTYPE) || (m_op == OP_ADDI) || (m_op == OP_LW) ||
                 (m_op == OP_SETX) || m_jal || m_ovf;
    m_regwrite = m_valid && m_writes && (m_rd != 5'd0);
    m_is_lw    = m_valid && (m_op == OP_LW) && !m_ovf;
  end

  assign bus.dmem_addr  = m_addr;
  assign bus.dmem_data  = m_b;
  assign bus.dmem_wren  = m_valid && (m_op == OP_SW) && !m_ovf;
  assign bus.m_rd       = m_rd;
  assign bus.m_value    = m_value;
  assign bus.m_regwrite = m_regwrite;

  logic        w_valid;
  logic [4:0]  w_rd;
  logic [31:0] w_value;
  logic        w_regwrite;
  logic        w_is_lw;
  logic [31:0] ret_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      w_valid    <= 1'b0;
      w_rd       <= '0;
      w_value    <= '0;
      w_regwrite <= 1'b0;
      w_is_lw    <= 1'b0;
      ret_cnt    <= '0;
    end else begin
      w_valid    <= m_valid;
      w_rd       <= m_rd;
      w_value    <= m_value;
      w_regwrite <= m_regwrite;
      w_is_lw    <= m_is_lw;
      ret_cnt    <= ret_cnt + {31'd0, w_valid};
    end
  end

  // dmem_q arrives registered one edge after the address, i.e. while the lw sits in W.
  assign bus.w_rd          = w_rd;
  assign bus.w_data        = w_is_lw ? bus.dmem_q : w_value;
  assign bus.w_regwrite    = w_valid && w_regwrite;
  assign bus.retired_count = ret_cnt;

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage with a registered-read data memory model.
module tb_mem_stage;

  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  mem_stage_if #(.DMEM_AW(12)) bus ();

  mem_stage #(.DMEM_AW(12), .RSTATUS(30), .RLINK(31)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] mem [0:4095];
  always @(posedge clock) begin
    if (bus.dmem_wren) mem[bus.dmem_addr] <= bus.dmem_data;
    bus.dmem_q <= mem[bus.dmem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] aluop);
    return {5'b00000, rd, 15'd0, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd, input logic [16:0] imm);
    return {op, rd, 5'd0, imm};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] b,
                       input logic [31:0] pcj, input logic ovf, input logic jal);
    bus.x_valid    = 1'b1;
    bus.x_ir       = ir;
    bus.x_alu_out  = alu;
    bus.x_b_out    = b;
    bus.x_pc_jal   = pcj;
    bus.x_overflow = ovf;
    bus.x_case_jal = jal;
  endtask

  task automatic idle();
    bus.x_valid    = 1'b0;
    bus.x_ir       = '0;
    bus.x_alu_out  = '0;
    bus.x_b_out    = '0;
    bus.x_pc_jal   = '0;
    bus.x_overflow = 1'b0;
    bus.x_case_jal = 1'b0;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    bus.stall = 1'b0;
    reset     = 1'b1;
    // Reset must win over a valid instruction presented at the same edge.
    drive(rtype(5'd3, ALU_ADD), 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    step();
    step();
    check("rst_wren", bus.dmem_wren, 0);
    check("rst_m_regwrite", bus.m_regwrite, 0);
    check("rst_w_regwrite", bus.w_regwrite, 0);
    check("rst_w_rd", bus.w_rd, 0);
    check("rst_w_data", bus.w_data, 0);
    check("rst_retired", bus.retired_count, 0);
    reset = 1'b0;

    drive(rtype(5'd3, ALU_ADD), 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    step();
    check("add_m_rd", bus.m_rd, 3);
    check("add_m_value", bus.m_value, 7);
    check("add_m_regwrite", bus.m_regwrite, 1);
    idle();
    step();
    check("add_w_rd", bus.w_rd, 3);
    check("add_w_data", bus.w_data, 7);
    check("add_w_regwrite", bus.w_regwrite, 1);
    check("add_retired_pre", bus.retired_count, 0);
    step();
    check("add_retired", bus.retired_count, 1);

    drive(itype(OP_SW, 5'd2, 17'd0), 32'h0000_0A05, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
    step();
    check("sw_wren", bus.dmem_wren, 1);
    check("sw_addr", bus.dmem_addr, 32'hA05);
    check("sw_data", bus.dmem_data, 32'hDEAD_BEEF);
    check("sw_m_regwrite", bus.m_regwrite, 0);
    drive(itype(OP_LW, 5'd5, 17'd0), 32'h0000_0A05, 32'd0, 32'd0, 1'b0, 1'b0);
    step();
    check("lw_wren", bus.dmem_wren, 0);
    check("lw_addr", bus.dmem_addr, 32'hA05);
    check("lw_m_regwrite", bus.m_regwrite, 1);
    check("sw_w_regwrite", bus.w_regwrite, 0);
    idle();
    step();
    check("lw_w_rd", bus.w_rd, 5);
    check("lw_w_data", bus.w_data, 32'hDEAD_BEEF);
    check("lw_w_regwrite", bus.w_regwrite, 1);
    check("sw_retired", bus.retired_count, 2);
    step();
    check("lw_retired", bus.retired_count, 3);

    drive(itype(OP_ADDI, 5'd7, 17'd1), 32'h55, 32'd0, 32'd0, 1'b1, 1'b0);
    step();
    check("addi_ovf_m_rd", bus.m_rd, 30);
    check("addi_ovf_m_value", bus.m_value, 2);
    check("addi_ovf_wren", bus.dmem_wren, 0);
    drive(rtype(5'd4, ALU_SUB), 32'h66, 32'd0, 32'd0, 1'b1, 1'b0);
    step();
    check("addi_ovf_w_rd", bus.w_rd, 30);
    check("addi_ovf_w_data", bus.w_data, 2);
    check("addi_ovf_w_regwrite", bus.w_regwrite, 1);
    check("sub_ovf_m_value", bus.m_value, 3);
    drive(rtype(5'd6, ALU_DIV), 32'h77, 32'd0, 32'd0, 1'b1, 1'b0);
    step();
    check("sub_ovf_w_data", bus.w_data, 3);
    idle();
    step();
    check("div_ovf_w_rd", bus.w_rd, 30);
    check("div_ovf_w_data", bus.w_data, 5);
    check("div_ovf_wren", bus.dmem_wren, 0);

    drive({OP_JAL, 27'h100}, 32'h999, 32'd0, 32'h40, 1'b0, 1'b1);
    step();
    idle();
    step();
    check("jal_w_rd", bus.w_rd, 31);
    check("jal_w_data", bus.w_data, 32'h40);
    check("jal_w_regwrite", bus.w_regwrite, 1);
    drive({OP_SETX, 27'h123}, 32'h888, 32'd0, 32'd0, 1'b0, 1'b0);
    step();
    idle();
    step();
    check("setx_w_rd", bus.w_rd, 30);
    check("setx_w_data", bus.w_data, 32'h123);
    drive(rtype(5'd0, ALU_ADD), 32'd9, 32'd0, 32'd0, 1'b0, 1'b0);
    step();
    check("r0_m_regwrite", bus.m_regwrite, 0);
    idle();
    step();
    check("r0_w_regwrite", bus.w_regwrite, 0);

    drive(itype(OP_SW, 5'd1, 17'd0), 32'h10, 32'h1234, 32'd0, 1'b0, 1'b0);
    step();
    check("rst_sw_wren_pre", bus.dmem_wren, 1);
    idle();
    reset = 1'b1;
    step();
    check("rst_sw_wren", bus.dmem_wren, 0);
    check("rst_sw_w_regwrite", bus.w_regwrite, 0);
    check("rst_sw_retired", bus.retired_count, 0);
    check("rst_sw_w_data", bus.w_data, 0);
    reset = 1'b0;

    drive(rtype(5'd9, ALU_ADD), 32'h11, 32'd0, 32'd0, 1'b0, 1'b0);
    step();
    drive(rtype(5'd10, ALU_MUL), 32'h22, 32'd0, 32'd0, 1'b0, 1'b0);
    bus.stall = 1'b1;
    step();
    check("stall1_m_regwrite", bus.m_regwrite, 0);
    check("stall1_w_rd", bus.w_rd, 9);
    check("stall1_w_data", bus.w_data, 32'h11);
    check("stall1_w_regwrite", bus.w_regwrite, 1);
    check("stall1_retired", bus.retired_count, 0);
    step();
    check("stall2_m_regwrite", bus.m_regwrite, 0);
    check("stall2_w_regwrite", bus.w_regwrite, 0);
    check("stall2_retired", bus.retired_count, 1);
    step();
    check("stall3_m_regwrite", bus.m_regwrite, 0);
    check("stall3_retired", bus.retired_count, 1);
    bus.stall = 1'b0;
    step();
    check("mul_m_rd", bus.m_rd, 10);
    check("mul_m_value", bus.m_value, 32'h22);
    check("mul_m_regwrite", bus.m_regwrite, 1);
    idle();
    step();
    check("mul_w_rd", bus.w_rd, 10);
    check("mul_w_data", bus.w_data, 32'h22);
    check("mul_retired_pre", bus.retired_count, 1);
    step();
    check("mul_retired", bus.retired_count, 2);

    force dut.ret_cnt = 32'hFFFF_FFFF;
    step();
    step();
    release dut.ret_cnt;
    drive(rtype(5'd1, ALU_ADD), 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);
    step();
    idle();
    step();
    step();
    check("wrap_retired", bus.retired_count, 0);
    step();
    check("wrap_hold", bus.retired_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
